dmem_bus_arbiter: RTL

//  Shares the single data-memory/IO bus (feeding the IO and DMem controllers) between the CPU memory stage and a
//  DMA/loader port. The CPU has fixed priority. A DMA burst holds the bus once it is granted. A starvation guard

---
 rtl/dmem_bus_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the shared data-memory/IO bus between the CPU memory stage (fixed priority) and a DMA/loader port.
// Optional performance counters are enabled with `define ARB_PERF_CNT_EN.
module dmem_bus_arbiter #(
   parameter int unsigned DBITS        = 32,
   parameter int unsigned MAX_BURST    = 8,
   parameter int unsigned STARVE_LIMIT = 15
) (
   input  logic             clk,
   input  logic             reset,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0]      perfCpuStall,
   output logic [31:0]      perfDmaBeats,
`endif
   input  logic             cpuReq,
   input  logic             cpuWe,
   input  logic [DBITS-1:0] cpuAddr,
   input  logic [DBITS-1:0] cpuWdata,
   output logic             cpuStall,
   output logic [DBITS-1:0] cpuRdata,
   output logic             cpuRvalid,
   input  logic             dmaReq,
   input  logic             dmaWe,
   input  logic [DBITS-1:0] dmaAddr,
   input  logic [DBITS-1:0] dmaWdata,
   input  logic             dmaLast,
   output logic             dmaGnt,
   output logic [DBITS-1:0] dmaRdata,
   output logic             dmaRvalid,
   output logic [DBITS-1:0] busAddr,
   output logic [DBITS-1:0] busWdata,
   output logic             busWe,
   input  logic [DBITS-1:0] busRdata
);

   localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {OWN_CPU, OWN_DMA} ownerT;

   ownerT          owner, ownerNext;
   logic [BCW-1:0] beatCnt, beatNext;
   logic [SCW-1:0] starveCnt, starveNext;
   logic           rdValid, rdDma;
   logic           cpuWin, dmaWin, forceDma;

   assign forceDma = dmaReq && (starveCnt == SCW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner     <= OWN_CPU;
         beatCnt   <= '0;
         starveCnt <= '0;
         rdValid   <= 1'b0;
         rdDma     <= 1'b0;
      end else begin
         owner     <= ownerNext;
         beatCnt   <= beatNext;
         starveCnt <= starveNext;
         rdValid   <= (cpuWin && !cpuWe) || (dmaWin && !dmaWe);
         rdDma     <= dmaWin;
      end
   end

   // Winner selection is suppressed while reset is low so every output sits at its reset value.
   always_comb begin
      cpuWin    = 1'b0;
      dmaWin    = 1'b0;
      ownerNext = owner;
      beatNext  = beatCnt;
      if (reset) begin
         unique case (owner)
            OWN_CPU: begin
               if (cpuReq && !forceDma) begin
                  cpuWin = 1'b1;
               end else if (dmaReq) begin
                  dmaWin = 1'b1;
                  if (!dmaLast && (MAX_BURST > 1)) begin
                     ownerNext = OWN_DMA;
                     beatNext  = BCW'(1);
                  end
               end
            end
            OWN_DMA: begin
               dmaWin = dmaReq;
               if (!dmaReq || dmaLast || (beatCnt == BCW'(MAX_BURST - 1))) begin
                  ownerNext = OWN_CPU;
                  beatNext  = '0;
               end else begin
                  beatNext = beatCnt + 1'b1;
               end
            end
            default: ownerNext = OWN_CPU;
         endcase
      end
   end

   always_comb begin
      starveNext = starveCnt;
      if (dmaWin) begin
         starveNext = '0;
      end else if (reset && dmaReq && (starveCnt != SCW'(STARVE_LIMIT))) begin
         starveNext = starveCnt + 1'b1;
      end
   end

   assign cpuStall = reset && cpuReq && !cpuWin;
   assign dmaGnt   = dmaWin;

   always_comb begin
      busAddr  = '0;
      busWdata = '0;
      busWe    = 1'b0;
      if (cpuWin) begin
         busAddr  = cpuAddr;
         busWdata = cpuWdata;
         busWe    = cpuWe;
      end else if (dmaWin) begin
         busAddr  = dmaAddr;
         busWdata = dmaWdata;
         busWe    = dmaWe;
      end
   end

   assign cpuRvalid = rdValid && !rdDma;
   assign dmaRvalid = rdValid && rdDma;
   assign cpuRdata  = cpuRvalid ? busRdata : '0;
   assign dmaRdata  = dmaRvalid ? busRdata : '0;

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perfCpuStall <= '0;
         perfDmaBeats <= '0;
      end else begin
         if (cpuReq && cpuStall) perfCpuStall <= perfCpuStall + 32'd1;
         if (dmaGnt)             perfDmaBeats <= perfDmaBeats + 32'd1;
      end
   end
`endif

endmodule
